// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C register-access engine. Turns one command into a
// START / dev / reg / data (or read byte + master NACK) / STOP frame on open-drain SCL/SDA.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StSendDev,
        StAckDev,
        StSendReg,
        StAckReg,
        StSendData,
        StAckData,
        StReadData,
        StMnack,
        StStop,
        StDone
    } state_e;

    localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic        nack_q, nack_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_nack_q, rsp_nack_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;

    logic wrap;
    logic sample;
    logic slot_end;

    // Pin drive for a slot type and quarter phase, returned as {scl_oe, sda_oe}.
    function automatic logic [1:0] line_drive(input state_e st, input logic [1:0] ph,
                                              input logic tx_bit);
        logic [1:0] drv;
        drv = 2'b00;
        case (st)
            StStart:                             drv = {ph == 2'd3, ph[1]};
            StSendDev, StSendReg, StSendData:    drv = {~ph[1], ~tx_bit};
            StAckDev, StAckReg, StAckData,
            StReadData, StMnack:                 drv = {~ph[1], 1'b0};
            StStop:                              drv = {ph == 2'd0, ph != 2'd3};
            default:                             drv = 2'b00;
        endcase
        return drv;
    endfunction

    assign wrap     = (div_q == DivLast);
    // sda_i is taken on the last clk of phase 2, i.e. while SCL is high.
    assign sample   = wrap && (phase_q == 2'd2);
    assign slot_end = wrap && (phase_q == 2'd3);

    // Next-state, datapath and registered pin/response values.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        reg_addr_d  = reg_addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        nack_d      = nack_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;

        if (state_q != StIdle && state_q != StDone) begin
            div_d = wrap ? 16'd0 : div_q + 16'd1;
            if (wrap) begin
                phase_d = phase_q + 2'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    state_d     = StStart;
                    shift_d     = {cmd_dev_addr, cmd_rw};
                    reg_addr_d  = cmd_reg_addr;
                    wdata_d     = cmd_wdata;
                    rw_d        = cmd_rw;
                    nack_d      = 1'b0;
                    div_d       = 16'd0;
                    phase_d     = 2'd0;
                    bit_cnt_d   = 3'd7;
                end
            end
            StStart: begin
                if (slot_end) state_d = StSendDev;
            end
            StSendDev, StSendReg, StSendData: begin
                if (slot_end) begin
                    // Counter wraps 0 -> 7, ready for the following byte.
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    shift_d   = {shift_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0) begin
                        state_d = (state_q == StSendDev) ? StAckDev :
                                  (state_q == StSendReg) ? StAckReg : StAckData;
                    end
                end
            end
            StAckDev, StAckReg, StAckData: begin
                if (sample && sda_i) nack_d = 1'b1;
                if (slot_end) begin
                    if (nack_q || state_q == StAckData) begin
                        state_d = StStop;
                    end else if (state_q == StAckDev) begin
                        state_d = StSendReg;
                        shift_d = reg_addr_q;
                    end else if (rw_q) begin
                        state_d = StReadData;
                    end else begin
                        state_d = StSendData;
                        shift_d = wdata_q;
                    end
                end
            end
            StReadData: begin
                if (sample) rx_d = {rx_q[6:0], sda_i};
                if (slot_end) begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        state_d     = StMnack;
                        rsp_rdata_d = rx_q;
                    end
                end
            end
            StMnack: begin
                if (slot_end) state_d = StStop;
            end
            StStop: begin
                if (slot_end) state_d = StDone;
            end
            StDone: begin
                rsp_valid_d = 1'b1;
                rsp_nack_d  = nack_q;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        {scl_oe_d, sda_oe_d} = line_drive(state_d, phase_d, shift_d[7]);
    end

    // State and output registers; reset releases both bus lines immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            div_q       <= 16'd0;
            phase_q     <= 2'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_q        <= 8'd0;
            reg_addr_q  <= 8'd0;
            wdata_q     <= 8'd0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_nack_q  <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            nack_q      <= nack_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = ~cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: two engines (CLK_DIV 4 and 1) sharing one bus and an 8-register slave.
module tb_i2c_master_ctrl;

    localparam logic [6:0] SlvAddr = 7'h50;

    typedef struct {
        logic [7:0]      rdata;
        logic            nack;
        int              lat;
        int              acc;
        int              nb;
        logic [2:0][7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid4, cmd_valid1, cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg, cmd_wdata;
    logic       cmd_ready4, rsp_valid4, rsp_nack4, busy4, scl_oe4, sda_oe4;
    logic       cmd_ready1, rsp_valid1, rsp_nack1, busy1, scl_oe1, sda_oe1;
    logic [7:0] rsp_rdata4, rsp_rdata1;
    logic       slv_drive;
    logic       scl_line, sda_line;
    logic       sel;
    logic       ready_m, rsp_valid_m, rsp_nack_m;
    logic [7:0] rsp_rdata_m;

    assign scl_line    = ~(scl_oe4 | scl_oe1);
    assign sda_line    = ~(sda_oe4 | sda_oe1 | slv_drive);
    assign ready_m     = sel ? cmd_ready1 : cmd_ready4;
    assign rsp_valid_m = sel ? rsp_valid1 : rsp_valid4;
    assign rsp_nack_m  = sel ? rsp_nack1 : rsp_nack4;
    assign rsp_rdata_m = sel ? rsp_rdata1 : rsp_rdata4;

    i2c_master_ctrl #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_rw(cmd_rw), .cmd_dev_addr(cmd_dev), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_nack(rsp_nack4), .busy(busy4),
        .scl_oe(scl_oe4), .sda_oe(sda_oe4), .sda_i(sda_line)
    );

    i2c_master_ctrl #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_rw(cmd_rw), .cmd_dev_addr(cmd_dev), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_nack(rsp_nack1), .busy(busy1),
        .scl_oe(scl_oe1), .sda_oe(sda_oe1), .sda_i(sda_line)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_rsp_cyc = 0;
    int         last_acc = 0;
    exp_t       exp_q[$];
    logic [7:0] bus_q[$];
    logic [7:0] model_mem[8];
    logic [7:0] m_rdata[2];
    logic [7:0] slv_mem[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) cmd_valid1 = v;
        else cmd_valid4 = v;
    endtask

    // Drive one command; on acceptance push the reference model's expected response.
    task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input bit keep, input bit chk_b2b);
        exp_t e;
        int   slots;
        int   idx;
        bit   got;
        idx       = sel ? 1 : 0;
        cmd_rw    = rw;
        cmd_dev   = dev;
        cmd_reg   = rg;
        cmd_wdata = wd;
        set_valid(1'b1);
        got = 0;
        for (int t = 0; t < 3000 && !got; t++) begin
            if (ready_m) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
            set_valid(1'b0);
            return;
        end
        last_acc = cyc;
        if (chk_b2b) check("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
        e.acc  = cyc;
        e.nb   = 1;
        e.b    = '0;
        e.b[0] = {dev, rw};
        if (dev != SlvAddr) begin
            e.nack = 1'b1;
            slots  = 11;
        end else begin
            e.nb   = 2;
            e.b[1] = rg;
            if (rg >= 8'd8) begin
                e.nack = 1'b1;
                slots  = 20;
            end else begin
                e.nack = 1'b0;
                slots  = 29;
                if (rw) begin
                    m_rdata[idx] = model_mem[rg[2:0]];
                end else begin
                    model_mem[rg[2:0]] = wd;
                    e.nb   = 3;
                    e.b[2] = wd;
                end
            end
        end
        e.rdata = m_rdata[idx];
        e.lat   = slots * 4 * (sel ? 1 : 4) + 2;
        exp_q.push_back(e);
        @(negedge clk);
        if (!keep) set_valid(1'b0);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_cmd_ready4", cmd_ready4, 1);
        check("rst_busy4", busy4, 0);
        check("rst_rsp_valid4", rsp_valid4, 0);
        check("rst_rsp_rdata4", rsp_rdata4, 0);
        check("rst_rsp_nack4", rsp_nack4, 0);
        check("rst_scl_oe4", scl_oe4, 0);
        check("rst_sda_oe4", sda_oe4, 0);
        check("rst_cmd_ready1", cmd_ready1, 1);
        check("rst_scl_oe1", scl_oe1, 0);
    endtask

    // Scoreboard monitor: every response must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid_m) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata_m, e.rdata);
                    check("rsp_nack", rsp_nack_m, e.nack);
                    check("rsp_latency", cyc - e.acc, e.lat);
                    check("bus_nbytes", bus_q.size(), e.nb);
                    for (int i = 0; i < e.nb && i < bus_q.size(); i++) begin
                        check("bus_byte", bus_q[i], e.b[i]);
                    end
                end
                bus_q.delete();
                last_rsp_cyc = cyc;
            end
        end
    end

    // Bench I2C slave: address SlvAddr, registers 0..7, NACKs foreign addresses and reg >= 8.
    int         s_mode;
    int         s_bits;
    int         s_byte;
    logic [7:0] s_sh;
    logic       s_rw;
    logic [2:0] s_ptr;
    logic       scl_p, sda_p, scl_c, sda_c;
    bit         s_ok;

    initial begin : slave
        slv_drive = 1'b0;
        s_mode = 0; s_bits = 0; s_byte = 0; s_sh = '0; s_rw = 1'b0; s_ptr = '0;
        scl_p = 1'b1; sda_p = 1'b1;
        forever begin
            @(negedge clk);
            scl_c = scl_line;
            sda_c = sda_line;
            if (!rst) begin
                s_mode = 0;
                slv_drive = 1'b0;
            end else if (scl_p && scl_c && sda_p && !sda_c) begin
                s_mode = 1; s_bits = 0; s_byte = 0; slv_drive = 1'b0;
            end else if (scl_p && scl_c && !sda_p && sda_c) begin
                s_mode = 0; slv_drive = 1'b0;
            end else if (!scl_p && scl_c) begin
                if (s_mode == 1) begin
                    s_sh = {s_sh[6:0], sda_c};
                    s_bits++;
                end else if (s_mode == 4) begin
                    check("mnack_sda_released", sda_c, 1);
                    s_mode = 0;
                end
            end else if (scl_p && !scl_c) begin
                case (s_mode)
                    1: if (s_bits == 8) begin
                        bus_q.push_back(s_sh);
                        s_ok = 1;
                        if (s_byte == 0) begin
                            s_ok = (s_sh[7:1] == SlvAddr);
                            s_rw = s_sh[0];
                        end else if (s_byte == 1) begin
                            s_ok  = (s_sh < 8'd8);
                            s_ptr = s_sh[2:0];
                        end else begin
                            slv_mem[s_ptr] = s_sh;
                        end
                        if (s_ok) begin
                            slv_drive = 1'b1;
                            s_mode = 2;
                        end else begin
                            s_mode = 0;
                        end
                    end
                    2: begin
                        slv_drive = 1'b0;
                        s_byte++;
                        s_bits = 0;
                        if (s_byte == 2 && s_rw) begin
                            s_sh = slv_mem[s_ptr];
                            slv_drive = ~s_sh[7];
                            s_bits = 1;
                            s_mode = 3;
                        end else begin
                            s_mode = 1;
                        end
                    end
                    3: if (s_bits == 8) begin
                        slv_drive = 1'b0;
                        s_mode = 4;
                    end else begin
                        s_sh = {s_sh[6:0], 1'b0};
                        slv_drive = ~s_sh[7];
                        s_bits++;
                    end
                    default: ;
                endcase
            end
            scl_p = scl_c;
            sda_p = sda_c;
        end
    end

    initial begin : stim
        logic [6:0] dev;
        logic [7:0] rg;
        sel = 1'b0;
        cmd_valid4 = 1'b0; cmd_valid1 = 1'b0; cmd_rw = 1'b0;
        cmd_dev = '0; cmd_reg = '0; cmd_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            model_mem[i] = 8'h00;
            slv_mem[i]   = 8'h00;
        end
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed write, read-back, and address NACK.
        issue(1'b0, SlvAddr, 8'h03, 8'hA5, 0, 0);
        wait_done();
        check("slv_reg3", slv_mem[3], 8'hA5);
        issue(1'b1, SlvAddr, 8'h03, 8'h00, 0, 0);
        wait_done();
        issue(1'b0, 7'h51, 8'h03, 8'h77, 0, 0);
        wait_done();

        // Back-to-back with cmd_valid held: eight writes then eight reads.
        for (int n = 0; n < 8; n++) issue(1'b0, SlvAddr, 8'(n), 8'(8'h10 + n), 1, n > 0);
        for (int n = 0; n < 8; n++) issue(1'b1, SlvAddr, 8'(n), 8'h00, n < 7, 1);
        wait_done();

        // Randomized traffic, including foreign addresses and out-of-range registers.
        for (int n = 0; n < 30; n++) begin
            dev = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SlvAddr;
            rg  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            issue(1'($urandom), dev, rg, 8'($urandom), 0, 0);
            wait_done();
        end

        // Reset during SEND_REG bit 4 (slot 13, phase 0): lines released, no response.
        issue(1'b0, SlvAddr, 8'h02, 8'hC3, 0, 0);
        model_mem[2] = slv_mem[2];
        while (cyc < last_acc + 1 + 13 * 16 + 2) @(negedge clk);
        check("pre_rst_scl_oe", scl_oe4, 1);
        check("pre_rst_sda_oe", sda_oe4, 1);
        rst = 1'b0;
        #1;
        check("midrst_scl_oe", scl_oe4, 0);
        check("midrst_sda_oe", sda_oe4, 0);
        exp_q.delete();
        bus_q.delete();
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (600) @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready4, 1);
        check("post_rst_rdata", rsp_rdata4, 0);
        issue(1'b0, SlvAddr, 8'h02, 8'h3C, 0, 0);
        wait_done();
        issue(1'b1, SlvAddr, 8'h02, 8'h00, 0, 0);
        wait_done();

        // Fastest divider.
        sel = 1'b1;
        issue(1'b0, SlvAddr, 8'h07, 8'h5A, 0, 0);
        wait_done();
        issue(1'b1, SlvAddr, 8'h07, 8'h00, 0, 0);
        wait_done();
        for (int n = 0; n < 10; n++) begin
            dev = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SlvAddr;
            rg  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            issue(1'($urandom), dev, rg, 8'($urandom), 0, 0);
            wait_done();
        end

        for (int i = 0; i < 8; i++) check("slv_mem_final", slv_mem[i], model_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
